decode_fwd_ctrl: RTL and testbench

Hazard scheduler for the decode stage. It keeps a shift-register scoreboard of register writes still in flight in the `POST_DEC_LD` stages after decode, and from it drives the per-stage forwarding selects (`fwd_sig_from`) consumed by the decode value-decision logic. It also raises `stall` on a load-use hazard, so that the decode stage holds its head instruction and injects a bubble until load data can be forwarded.

---
 rtl/decode_fwd_ctrl.sv | 98 +++++++++
 tb/tb_decode_fwd_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_fwd_ctrl.sv
// Decode-stage hazard scheduler: shift-register scoreboard of in-flight register
// writes, per-stage forward selects, and load-use stall generation.
module decode_fwd_ctrl #(
    parameter int POST_DEC_LD      = 3,
    parameter int REG_N            = 16,
    parameter int REG_W            = 4,
    parameter int RIP_IDX          = 15,
    parameter int LOAD_READY_STAGE = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          issue_valid,
    input  logic [REG_W-1:0]              issue_d,
    input  logic [REG_W-1:0]              issue_s,
    input  logic [REG_W-1:0]              issue_t,
    input  logic [2:0]                    issue_use,
    input  logic                          issue_wr,
    input  logic [REG_W-1:0]              issue_wreg,
    input  logic                          issue_is_load,
    input  logic                          flush,
    output logic [POST_DEC_LD-1:0][2:0]   fwd_sig_from,
    output logic                          stall,
    output logic [31:0]                   stall_cycles
);

    localparam logic [REG_W-1:0] RIP = REG_W'(RIP_IDX);

    // Scoreboard: entry 0 is the youngest post-decode instruction.
    logic [POST_DEC_LD-1:0]             sb_v;
    logic [POST_DEC_LD-1:0][REG_W-1:0]  sb_wreg;
    logic [POST_DEC_LD-1:0]             sb_ld;

    logic [2:0][REG_W-1:0]              ops;
    logic [POST_DEC_LD-1:0][2:0]        hit;
    logic [2:0]                         haz;
    logic                               found;
    logic                               young_ld;
    int                                 young_idx;
    logic                               wreg_ok;
    logic                               insert;

    // Operand order {d,s,t}: bit 2 = d, bit 1 = s, bit 0 = t.
    always_comb begin
        ops[2]    = issue_d;
        ops[1]    = issue_s;
        ops[0]    = issue_t;
        hit       = '0;
        haz       = '0;
        found     = 1'b0;
        young_ld  = 1'b0;
        young_idx = 0;
        for (int x = 0; x < 3; x++) begin
            found     = 1'b0;
            young_ld  = 1'b0;
            young_idx = 0;
            // Walk oldest to youngest so the last hit seen is the youngest producer.
            for (int i = POST_DEC_LD - 1; i >= 0; i--) begin
                hit[i][x] = sb_v[i] && (sb_wreg[i] == ops[x]) && (ops[x] != RIP);
                if (hit[i][x]) begin
                    found     = 1'b1;
                    young_ld  = sb_ld[i];
                    young_idx = i;
                end
            end
            haz[x] = issue_valid && issue_use[x] && found && young_ld
                     && (young_idx < LOAD_READY_STAGE);
        end
    end

    assign fwd_sig_from = hit;
    assign stall        = |haz;

    // Out-of-range destinations name no architectural register and are not tracked.
    assign wreg_ok = (int'(issue_wreg) < REG_N) && (issue_wreg != RIP);
    assign insert  = issue_valid && issue_wr && !stall && !flush && wreg_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_v         <= '0;
            sb_wreg      <= '0;
            sb_ld        <= '0;
            stall_cycles <= '0;
        end else begin
            for (int i = 1; i < POST_DEC_LD; i++) begin
                sb_v[i]    <= sb_v[i-1];
                sb_wreg[i] <= sb_wreg[i-1];
                sb_ld[i]   <= sb_ld[i-1];
            end
            sb_v[0]    <= insert;
            sb_wreg[0] <= issue_wreg;
            sb_ld[0]   <= insert && issue_is_load;
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_fwd_ctrl.sv
// Directed bench for decode_fwd_ctrl: forwarding, load-use stalls, RIP, flush,
// counter saturation and asynchronous reset behaviour.
module tb_decode_fwd_ctrl;

    logic             clk;
    logic             rstn;
    logic             issue_valid;
    logic [3:0]       issue_d;
    logic [3:0]       issue_s;
    logic [3:0]       issue_t;
    logic [2:0]       issue_use;
    logic             issue_wr;
    logic [3:0]       issue_wreg;
    logic             issue_is_load;
    logic             flush;
    logic [2:0][2:0]  fwd_sig_from;
    logic             stall;
    logic [31:0]      stall_cycles;

    int n_checks;
    int n_errors;

    decode_fwd_ctrl #(
        .POST_DEC_LD(3), .REG_N(16), .REG_W(4), .RIP_IDX(15), .LOAD_READY_STAGE(2)
    ) dut (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid),
        .issue_d(issue_d), .issue_s(issue_s), .issue_t(issue_t),
        .issue_use(issue_use), .issue_wr(issue_wr), .issue_wreg(issue_wreg),
        .issue_is_load(issue_is_load), .flush(flush),
        .fwd_sig_from(fwd_sig_from), .stall(stall), .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_fwd, input int exp_stall);
        check({tag, "_fwd"}, 32'(fwd_sig_from), 32'(exp_fwd));
        check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    endtask

    task automatic drive(input int vld, input int d, input int s, input int t, input int use_m,
                         input int wr, input int wreg, input int ld, input int fl);
        issue_valid   = 1'(vld);
        issue_d       = 4'(d);
        issue_s       = 4'(s);
        issue_t       = 4'(t);
        issue_use     = 3'(use_m);
        issue_wr      = 1'(wr);
        issue_wreg    = 4'(wreg);
        issue_is_load = 1'(ld);
        flush         = 1'(fl);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with a live reader on the issue port
        rstn = 1'b0;
        drive(1, 0, 3, 0, 3'b010, 0, 0, 0, 0);
        #12;
        check_out("reset", 0, 0);
        check("reset_cnt", stall_cycles, 32'd0);
        #1 rstn = 1'b1;
        step();
        idle();
        #2 check_out("post_reset_idle", 0, 0);

        // ALU producer r5, reader of r5 as s held while producer ages
        step();
        drive(1, 0, 0, 0, 3'b000, 1, 5, 0, 0);
        #2 check_out("alu_wr", 0, 0);
        step();
        drive(1, 0, 5, 0, 3'b010, 0, 0, 0, 0);
        #2 check_out("alu_fwd0", 9'h002, 0);
        step();
        #2 check_out("alu_fwd1", 9'h010, 0);
        step();
        #2 check_out("alu_fwd2", 9'h080, 0);
        step();
        #2 check_out("alu_gone", 0, 0);

        // Load r7, then add r8 <- t=r7 (d=8 unused, probes for a premature insert)
        step();
        drive(1, 0, 0, 0, 3'b000, 1, 7, 1, 0);
        #2 check_out("ld_issue", 0, 0);
        step();
        drive(1, 8, 0, 7, 3'b001, 1, 8, 0, 0);
        #2 check_out("ldu_c1", 9'h001, 1);
        step();
        #2 check_out("ldu_c2", 9'h008, 1);
        check("ldu_cnt1", stall_cycles, 32'd1);
        step();
        #2 check_out("ldu_c3", 9'h040, 0);
        check("ldu_cnt2", stall_cycles, 32'd2);
        step();
        drive(1, 8, 0, 0, 3'b100, 0, 0, 0, 0);
        #2 check_out("ldu_dep_fwd", 9'h004, 0);
        check("ldu_cnt_hold", stall_cycles, 32'd2);
        drain();

        // Youngest producer wins: load r4, ALU r4, read r4
        drive(1, 0, 0, 0, 3'b000, 1, 4, 1, 0);
        #2 check_out("yw_ld", 0, 0);
        step();
        drive(1, 0, 0, 0, 3'b000, 1, 4, 0, 0);
        #2 check_out("yw_alu", 0, 0);
        step();
        drive(1, 0, 4, 0, 3'b010, 0, 0, 0, 0);
        #2 check_out("yw_read", 9'h012, 0);
        drain();

        // Operand-use mask and issue_valid gate the hazard
        drive(1, 0, 0, 0, 3'b000, 1, 6, 1, 0);
        step();
        drive(1, 0, 6, 0, 3'b000, 0, 0, 0, 0);
        #2 check_out("use0_nostall", 9'h002, 0);
        issue_use = 3'b010;
        #1 check("use_s_stall", 32'(stall), 32'd1);
        issue_valid = 1'b0;
        #1 check("invalid_nostall", 32'(stall), 32'd0);
        drain();
        check("cnt_after_yw", stall_cycles, 32'd2);

        // RIP write is dropped, RIP read never forwards; flush blocks only the insert
        drive(1, 0, 0, 0, 3'b000, 1, 15, 0, 0);
        #2 check_out("rip_wr", 0, 0);
        step();
        drive(1, 0, 15, 0, 3'b010, 1, 9, 0, 0);
        #2 check_out("rip_read", 0, 0);
        step();
        drive(1, 0, 0, 0, 3'b000, 1, 2, 0, 1);
        #2 check_out("flush_wr", 0, 0);
        step();
        drive(1, 9, 2, 0, 3'b110, 0, 0, 0, 0);
        #2 check_out("flush_read", 9'h020, 0);
        drain();

        // Flush and stall together still count
        drive(1, 0, 0, 0, 3'b000, 1, 3, 1, 0);
        step();
        drive(1, 0, 0, 3, 3'b001, 0, 0, 0, 1);
        #2 check_out("fl_stall", 9'h001, 1);
        step();
        idle();
        #2 check("fl_cnt", stall_cycles, 32'd3);
        check_out("fl_after", 0, 0);
        drain();

        // Counter saturation across three hazard cycles
        drive(1, 0, 0, 0, 3'b000, 1, 1, 1, 0);
        step();
        drive(1, 0, 1, 0, 3'b010, 0, 0, 0, 0);
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles;
        #1 check_out("sat_c1", 9'h002, 1);
        step();
        #2 check("sat_cnt1", stall_cycles, 32'hFFFF_FFFF);
        check("sat_c2_stall", 32'(stall), 32'd1);
        step();
        #2 check("sat_cnt2", stall_cycles, 32'hFFFF_FFFF);
        check("sat_c3_stall", 32'(stall), 32'd0);
        drive(1, 0, 0, 0, 3'b000, 1, 1, 1, 0);
        step();
        drive(1, 0, 1, 0, 3'b010, 0, 0, 0, 0);
        #2 check("sat_c4_stall", 32'(stall), 32'd1);
        step();
        #2 check("sat_cnt3", stall_cycles, 32'hFFFF_FFFF);
        check("sat_c5_stall", 32'(stall), 32'd1);

        // Asynchronous reset in the middle of a stall
        rstn = 1'b0;
        #1 check_out("rst_mid", 0, 0);
        check("rst_mid_cnt", stall_cycles, 32'd0);
        #1 rstn = 1'b1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
